// File: rtl/dcache_miss_fsm_pkg.sv
// ============================================================================
// dcache_miss_fsm_pkg : shared types, widths and helpers for the miss handler
// Revision: 1.0
// ============================================================================
`default_nettype none

package dcache_miss_fsm_pkg;

  localparam int NUM_SETS  = 4;
  localparam int NUM_WAYS  = 4;
  localparam int LINE_BITS = 128;
  localparam int ADDR_W    = 32;
  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int WAY_W     = $clog2(NUM_WAYS);
  localparam int OFF_W     = $clog2(LINE_BITS / 8);
  localparam int TAG_W     = ADDR_W - SET_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VICTIM   = 3'd1,
    META     = 3'd2,
    META_RSP = 3'd3,
    WB_REQ   = 3'd4,
    RD_REQ   = 3'd5,
    RD_WAIT  = 3'd6,
    FILL     = 3'd7
  } state_e;

  // Builds {tag, set, zero offset}; callers truncate to their address width.
  function automatic logic [63:0] line_addr(input logic [63:0] tag,
                                            input logic [63:0] set,
                                            input int          set_w,
                                            input int          off_w);
    return ((tag << set_w) | set) << off_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_miss_fsm_if.sv
// ============================================================================
// dcache_miss_fsm_if : lookup, LRU, metadata, memory and fill signals
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dcache_miss_fsm_if #(
  parameter int ADDR_W    = dcache_miss_fsm_pkg::ADDR_W,
  parameter int SET_W     = dcache_miss_fsm_pkg::SET_W,
  parameter int WAY_W     = dcache_miss_fsm_pkg::WAY_W,
  parameter int TAG_W     = dcache_miss_fsm_pkg::TAG_W,
  parameter int LINE_BITS = dcache_miss_fsm_pkg::LINE_BITS
);

  logic                 miss_req;
  logic [ADDR_W-1:0]    miss_addr;
  logic                 miss_ready;
  logic                 miss_done;

  logic                 victim_req;
  logic [SET_W-1:0]     victim_set;
  logic [WAY_W-1:0]     victim_way;

  logic                 meta_rd;
  logic [SET_W-1:0]     meta_set;
  logic [WAY_W-1:0]     meta_way;
  logic                 meta_valid;
  logic                 meta_dirty;
  logic [TAG_W-1:0]     meta_tag;
  logic [LINE_BITS-1:0] meta_data;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [LINE_BITS-1:0] mem_rdata;

  logic                 fill_valid;
  logic [SET_W-1:0]     fill_set;
  logic [WAY_W-1:0]     fill_way;
  logic [TAG_W-1:0]     fill_tag;
  logic [LINE_BITS-1:0] fill_data;

  logic                 update_req;
  logic [SET_W-1:0]     update_set;
  logic [WAY_W-1:0]     update_way;

  modport master (
    input  miss_req, miss_addr, victim_way,
    input  meta_valid, meta_dirty, meta_tag, meta_data,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, miss_done, victim_req, victim_set,
    output meta_rd, meta_set, meta_way,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output fill_valid, fill_set, fill_way, fill_tag, fill_data,
    output update_req, update_set, update_way
  );

  modport slave (
    output miss_req, miss_addr, victim_way,
    output meta_valid, meta_dirty, meta_tag, meta_data,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, miss_done, victim_req, victim_set,
    input  meta_rd, meta_set, meta_way,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_valid, fill_set, fill_way, fill_tag, fill_data,
    input  update_req, update_set, update_way
  );

endinterface

`default_nettype wire

// File: rtl/dcache_miss_fsm.sv
// ============================================================================
// dcache_miss_fsm : victim select, optional writeback, line fetch and fill
// Optional DCACHE_MISS_PERF_EN adds saturating miss/writeback counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_miss_fsm #(
  parameter int NUM_SETS  = dcache_miss_fsm_pkg::NUM_SETS,
  parameter int NUM_WAYS  = dcache_miss_fsm_pkg::NUM_WAYS,
  parameter int LINE_BITS = dcache_miss_fsm_pkg::LINE_BITS,
  parameter int ADDR_W    = dcache_miss_fsm_pkg::ADDR_W
) (
  input  wire               clock,
  input  wire               reset,
  dcache_miss_fsm_if.master bus
`ifdef DCACHE_MISS_PERF_EN
  ,
  output logic [31:0]       perf_miss_cnt,
  output logic [31:0]       perf_wb_cnt
`endif
);

  import dcache_miss_fsm_pkg::*;

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int TAG_W = ADDR_W - SET_W - OFF_W;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
  // One line register serves both the writeback payload and the fetched line.
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 unused_offset;

  assign rd_addr       = ADDR_W'(line_addr(64'(tag_q), 64'(set_q), SET_W, OFF_W));
  assign unused_offset = ^bus.miss_addr[OFF_W-1:0];

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    set_d     = set_q;
    way_d     = way_q;
    wb_addr_d = wb_addr_q;
    line_d    = line_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          tag_d   = bus.miss_addr[ADDR_W-1 -: TAG_W];
          set_d   = bus.miss_addr[OFF_W +: SET_W];
          state_d = VICTIM;
        end
      end
      VICTIM: begin
        way_d   = bus.victim_way;
        state_d = META;
      end
      META:     state_d = META_RSP;
      META_RSP: begin
        if (bus.meta_valid && bus.meta_dirty) begin
          wb_addr_d = ADDR_W'(line_addr(64'(bus.meta_tag), 64'(set_q), SET_W, OFF_W));
          line_d    = bus.meta_data;
          state_d   = WB_REQ;
        end else begin
          state_d = RD_REQ;
        end
      end
      WB_REQ: begin
        if (bus.mem_gnt) state_d = RD_REQ;
      end
      RD_REQ: begin
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            line_d  = bus.mem_rdata;
            state_d = FILL;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          line_d  = bus.mem_rdata;
          state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.miss_ready = 1'b0;
    bus.miss_done  = 1'b0;
    bus.victim_req = 1'b0;
    bus.victim_set = '0;
    bus.meta_rd    = 1'b0;
    bus.meta_set   = '0;
    bus.meta_way   = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.fill_valid = 1'b0;
    bus.fill_set   = '0;
    bus.fill_way   = '0;
    bus.fill_tag   = '0;
    bus.fill_data  = '0;
    bus.update_req = 1'b0;
    bus.update_set = '0;
    bus.update_way = '0;
    case (state_q)
      IDLE: bus.miss_ready = 1'b1;
      VICTIM: begin
        bus.victim_req = 1'b1;
        bus.victim_set = set_q;
      end
      META: begin
        bus.meta_rd  = 1'b1;
        bus.meta_set = set_q;
        bus.meta_way = way_q;
      end
      WB_REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wb_addr_q;
        bus.mem_wdata = line_q;
      end
      RD_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = rd_addr;
      end
      FILL: begin
        bus.fill_valid = 1'b1;
        bus.fill_set   = set_q;
        bus.fill_way   = way_q;
        bus.fill_tag   = tag_q;
        bus.fill_data  = line_q;
        bus.update_req = 1'b1;
        bus.update_set = set_q;
        bus.update_way = way_q;
        bus.miss_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      set_q     <= '0;
      way_q     <= '0;
      wb_addr_q <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      set_q     <= set_d;
      way_q     <= way_d;
      wb_addr_q <= wb_addr_d;
      line_q    <= line_d;
    end
  end

`ifdef DCACHE_MISS_PERF_EN
  logic [31:0] perf_miss_cnt_q, perf_miss_cnt_d;
  logic [31:0] perf_wb_cnt_q, perf_wb_cnt_d;

  always_comb begin
    perf_miss_cnt_d = perf_miss_cnt_q;
    perf_wb_cnt_d   = perf_wb_cnt_q;
    if (state_q == IDLE && bus.miss_req && perf_miss_cnt_q != 32'hFFFF_FFFF)
      perf_miss_cnt_d = perf_miss_cnt_q + 32'd1;
    if (state_q == WB_REQ && bus.mem_gnt && perf_wb_cnt_q != 32'hFFFF_FFFF)
      perf_wb_cnt_d = perf_wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_miss_cnt_q <= '0;
      perf_wb_cnt_q   <= '0;
    end else begin
      perf_miss_cnt_q <= perf_miss_cnt_d;
      perf_wb_cnt_q   <= perf_wb_cnt_d;
    end
  end

  assign perf_miss_cnt = perf_miss_cnt_q;
  assign perf_wb_cnt   = perf_wb_cnt_q;
`endif

endmodule

`default_nettype wire
